// File: rtl/controller_poller_pkg.sv
// Shared types and defaults for the game-pad poller.
package ctrl_pkg;

   // Frame sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LATCH = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Bit index width: eight buttons per frame
   localparam int IDX_W = 3;

   // Default timing
   localparam int CLK_DIV_DEF     = 4;
   localparam int POLL_PERIOD_DEF = 200;

endpackage

// File: rtl/controller_poller_if.sv
// Pad and core-side signals of the poller grouped into one bundle.
interface controller_poller_if;
   import ctrl_pkg::*;

   logic       poll_en;
   logic       pad_data;
   logic       pad_latch;
   logic       pad_clk;
   logic [7:0] controller_data;
   logic       int_req;
   logic       int_ack;

   // Poller side
   modport master (
      input  poll_en, pad_data, int_ack,
      output pad_latch, pad_clk, controller_data, int_req
   );

   // Host/pad side
   modport slave (
      output poll_en, pad_data, int_ack,
      input  pad_latch, pad_clk, controller_data, int_req
   );
endinterface

// File: rtl/controller_poller_sync2.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture; both stages reset to the idle level of the line
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/controller_poller.sv
// NES-style serial pad poller: periodic latch, 8-bit serial read,
// byte presentation and change interrupt with acknowledge.
module controller_poller
   import ctrl_pkg::*;
#(
   parameter int CLK_DIV     = CLK_DIV_DEF,
   parameter int POLL_PERIOD = POLL_PERIOD_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   controller_poller_if.master  bus
);

   localparam int PH_W = $clog2(2 * CLK_DIV);
   localparam int PC_W = $clog2(POLL_PERIOD);

   localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * CLK_DIV - 1);
   localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(CLK_DIV - 1);
   localparam logic [PH_W-1:0]  PH_HIGH   = PH_W'(CLK_DIV);
   localparam logic [PC_W-1:0]  PC_LAST   = PC_W'(POLL_PERIOD - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(7);

   state_e           state_q,     state_d;
   logic [PH_W-1:0]  phase_q,     phase_d;
   logic [IDX_W-1:0] idx_q,       idx_d;
   logic [PC_W-1:0]  poll_cnt_q,  poll_cnt_d;
   logic [7:0]       shift_q,     shift_d;
   logic [7:0]       data_q,      data_d;
   logic             int_req_q,   int_req_d;
   logic             pad_latch_q, pad_latch_d;
   logic             pad_clk_q,   pad_clk_d;
   logic             poll_start;
   logic             pad_sync;

   // Pad line idles high (no button pressed), so the synchroniser resets to 1
   sync2 #(
      .RST_VAL (1'b1)
   ) u_pad_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (bus.pad_data),
      .q_o   (pad_sync)
   );

   // Poll counter: free-runs through a frame so starts stay evenly spaced;
   // parked at zero while idle and disabled
   always_comb begin
      poll_cnt_d = poll_cnt_q + PC_W'(1);
      poll_start = 1'b0;
      if (state_q == IDLE) begin
         if (!bus.poll_en) begin
            poll_cnt_d = '0;
         end else if (poll_cnt_q == PC_LAST) begin
            poll_cnt_d = '0;
            poll_start = 1'b1;
         end
      end
   end

   // Frame sequencer next state, serial capture and interrupt set/clear
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      int_req_d = int_req_q;

      // Acknowledge clears; a set in DONE below overrides it
      if (bus.int_ack) int_req_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (poll_start) begin
               state_d = LATCH;
               phase_d = '0;
            end
         end
         LATCH: begin
            if (phase_q == PH_LAST) begin
               state_d = SHIFT;
               phase_d = '0;
               idx_d   = '0;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         SHIFT: begin
            // Capture at the end of the low half; wire is active-low
            if (phase_q == PH_SAMPLE) shift_d[idx_q] = ~pad_sync;
            if (phase_q == PH_LAST) begin
               phase_d = '0;
               if (idx_q == IDX_LAST) state_d = DONE;
               else                   idx_d   = idx_q + IDX_W'(1);
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         DONE: begin
            data_d = shift_q;
            if (shift_q != data_q) int_req_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Pad strobes are registered so they line up with the state register
      pad_latch_d = (state_d == LATCH);
      pad_clk_d   = (state_d == SHIFT) && (phase_d >= PH_HIGH);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         idx_q       <= '0;
         poll_cnt_q  <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         int_req_q   <= 1'b0;
         pad_latch_q <= 1'b0;
         pad_clk_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         idx_q       <= idx_d;
         poll_cnt_q  <= poll_cnt_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         int_req_q   <= int_req_d;
         pad_latch_q <= pad_latch_d;
         pad_clk_q   <= pad_clk_d;
      end
   end

   assign bus.pad_latch       = pad_latch_q;
   assign bus.pad_clk         = pad_clk_q;
   assign bus.controller_data = data_q;
   assign bus.int_req         = int_req_q;

endmodule

// File: tb/tb_controller_poller.sv
// Self-checking bench for controller_poller with a behavioural pad model.
module tb_controller_poller;

   localparam int C = 4;
   localparam int P = 200;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc;
   int   errors = 0;
   int   checks = 0;

   // Reference model state
   logic [7:0] exp_data = 8'h00;
   logic       exp_irq  = 1'b0;
   int         last_t   = 0;

   // Pad model: parallel load on latch, shift on rising pad_clk, active-low wire
   logic [7:0] pad_btn = 8'h00;
   logic [7:0] pad_sr  = 8'h00;

   controller_poller_if bus ();

   controller_poller #(
      .CLK_DIV     (C),
      .POLL_PERIOD (P)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Cycle label: value after edge k (k = 0 is first edge with reset high) is k+1
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc = 0;
      else        cyc = cyc + 1;
   end

   always @(posedge bus.pad_latch or posedge bus.pad_clk) begin
      if (bus.pad_latch) pad_sr = pad_btn;
      else               pad_sr = {1'b0, pad_sr[7:1]};
   end
   assign bus.pad_data = ~pad_sr[0];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_latch(input int limit, output int t, output bit ok);
      ok = 1'b0;
      t  = -1;
      for (int i = 0; i < limit && !ok; i++) begin
         if (bus.pad_latch === 1'b1) begin
            ok = 1'b1;
            t  = cyc;
         end else begin
            step();
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_latch: no pad_latch within %0d cycles, required one", limit);
      end
   endtask

   // One full frame checked cycle by cycle against the timing rules
   task automatic run_frame(input logic [7:0] btn, input bit ack_done,
                            input int drop_at, output int t);
      bit         ok;
      logic [7:0] prior;
      logic       exp_l, exp_c, new_irq;
      pad_btn = btn;
      wait_latch(2 * P, t, ok);
      if (!ok) return;
      prior = exp_data;
      for (int k = 0; k <= 18 * C; k++) begin
         exp_l = (k < 2 * C);
         exp_c = (k >= 2 * C) && (k < 18 * C) && (((k - 2 * C) % (2 * C)) >= C);
         checks++;
         if (bus.pad_latch !== exp_l || bus.pad_clk !== exp_c) begin
            errors++;
            $display("FAIL frame_pins: T+%0d latch=%b clk=%b required latch=%b clk=%b",
                     k, bus.pad_latch, bus.pad_clk, exp_l, exp_c);
         end
         checks++;
         if (bus.controller_data !== prior || bus.int_req !== exp_irq) begin
            errors++;
            $display("FAIL frame_hold: T+%0d data=%h irq=%b required data=%h irq=%b",
                     k, bus.controller_data, bus.int_req, prior, exp_irq);
         end
         if (k == drop_at) bus.poll_en = 1'b0;
         if (k == 18 * C && ack_done) bus.int_ack = 1'b1;
         step();
      end
      bus.int_ack = 1'b0;
      new_irq  = (btn != prior) || (exp_irq && !ack_done);
      exp_irq  = new_irq;
      exp_data = btn;
      checks++;
      if (bus.controller_data !== exp_data || bus.int_req !== exp_irq) begin
         errors++;
         $display("FAIL frame_update: T+%0d data=%h irq=%b required data=%h irq=%b",
                  18 * C + 1, bus.controller_data, bus.int_req, exp_data, exp_irq);
      end
      $display("frame T=%0d btn=%h ack_in_done=%0d data=%h irq=%b",
               t, btn, ack_done, bus.controller_data, bus.int_req);
   endtask

   task automatic pulse_ack();
      bus.int_ack = 1'b1;
      step();
      bus.int_ack = 1'b0;
      exp_irq = 1'b0;
      checks++;
      if (bus.int_req !== 1'b0) begin
         errors++;
         $display("FAIL ack_clear: irq=%b required 0", bus.int_req);
      end
      $display("ack cycle=%0d irq=%b", cyc, bus.int_req);
   endtask

   task automatic check_spacing(input int t);
      checks++;
      if (t - last_t !== P) begin
         errors++;
         $display("FAIL poll_spacing: got %0d required %0d", t - last_t, P);
      end
      last_t = t;
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (bus.pad_latch !== 1'b0 || bus.pad_clk !== 1'b0 ||
          bus.controller_data !== 8'h00 || bus.int_req !== 1'b0) begin
         errors++;
         $display("FAIL %s: latch=%b clk=%b data=%h irq=%b required 0 0 00 0",
                  tag, bus.pad_latch, bus.pad_clk, bus.controller_data, bus.int_req);
      end
      $display("%s data=%h irq=%b", tag, bus.controller_data, bus.int_req);
   endtask

   task automatic test_reset();
      bus.poll_en = 1'b1;
      bus.int_ack = 1'b0;
      pad_btn     = 8'h00;
      rst_n       = 1'b0;
      repeat (3) step();
      check_reset_outputs("reset_state");
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_data = 8'h00;
      exp_irq  = 1'b0;
   endtask

   task automatic test_idle_frame();
      int t;
      run_frame(8'h00, 1'b0, -1, t);
      checks++;
      if (t !== P) begin
         errors++;
         $display("FAIL first_latch: cycle %0d required %0d", t, P);
      end
      last_t = t;
   endtask

   task automatic test_change_irq();
      int t;
      run_frame(8'hA5, 1'b0, -1, t);
      check_spacing(t);
      pulse_ack();
   endtask

   task automatic test_no_change();
      int t;
      run_frame(8'hA5, 1'b0, -1, t);
      check_spacing(t);
      run_frame(8'h3C, 1'b0, -1, t);
      check_spacing(t);
   endtask

   task automatic test_ack_in_done();
      int t;
      pulse_ack();
      run_frame(8'hC3, 1'b1, -1, t);
      check_spacing(t);
      pulse_ack();
   endtask

   task automatic test_poll_en_drop();
      int  t, t2, e;
      bit  ok, seen;
      run_frame(8'h5A, 1'b0, 20, t);
      seen = 1'b0;
      while (cyc < t + P + 60) begin
         if (bus.pad_latch !== 1'b0) seen = 1'b1;
         step();
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL disabled_latch: latch=1 required 0 while poll_en=0");
      end
      pulse_ack();
      pad_btn = exp_data;
      e = cyc;
      bus.poll_en = 1'b1;
      wait_latch(2 * P, t2, ok);
      if (ok) begin
         checks++;
         if (t2 - e !== P) begin
            errors++;
            $display("FAIL reenable_latch: %0d cycles required %0d", t2 - e, P);
         end
         repeat (18 * C + 1) step();
         checks++;
         if (bus.controller_data !== exp_data || bus.int_req !== exp_irq) begin
            errors++;
            $display("FAIL reenable_frame: data=%h irq=%b required data=%h irq=%b",
                     bus.controller_data, bus.int_req, exp_data, exp_irq);
         end
         $display("reenable T=%0d data=%h irq=%b", t2, bus.controller_data, bus.int_req);
         last_t = t2;
      end
   endtask

   task automatic test_random_frames();
      int         t;
      logic [7:0] btn;
      bit         ackd;
      for (int i = 0; i < 6; i++) begin
         if (($urandom % 3) == 0) btn = exp_data;
         else                     btn = 8'($urandom);
         if ($urandom % 2) pulse_ack();
         ackd = 1'($urandom % 2);
         run_frame(btn, ackd, -1, t);
         check_spacing(t);
      end
      run_frame(8'hFF, 1'b0, -1, t);
      check_spacing(t);
   endtask

   task automatic test_reset_midframe();
      int t;
      bit ok;
      pad_btn = 8'h81;
      wait_latch(2 * P, t, ok);
      repeat (40) step();
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      step();
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_data = 8'h00;
      exp_irq  = 1'b0;
      step();
      check_reset_outputs("after_release");
      run_frame(8'h00, 1'b0, -1, t);
      checks++;
      if (t !== P) begin
         errors++;
         $display("FAIL latch_after_reset: cycle %0d required %0d", t, P);
      end
   endtask

   initial begin
      test_reset();
      test_idle_frame();
      test_change_irq();
      test_no_change();
      test_ack_in_done();
      test_poll_en_drop();
      test_random_frames();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
